// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl: stall/flush/redirect sequencer for the IF/ID/EX/MEM pipeline.
// Commits exceptions and ERET at MEM and owns STATUS/MASK/EXP_CODE/EPC/EXC_VEC.
module pipe_seq_ctrl #(
  parameter int unsigned       ADDR_W  = 30,
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       EXP_W   = 3,
  parameter int unsigned       IRQ_W   = 8,
  parameter logic [ADDR_W-1:0] VEC_RST = '0,
  parameter int unsigned       DRAIN_N = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IRQ_W-1:0]  irq_i,
  input  logic              if_busy_i,
  input  logic              mem_busy_i,
  input  logic              ld_hazard_i,
  input  logic [ADDR_W-1:0] mem_pc_i,
  input  logic              mem_en_i,
  input  logic              mem_br_flag_i,
  input  logic [EXP_W-1:0]  mem_exp_code_i,
  input  logic              mem_eret_i,
  input  logic              cr_we_i,
  input  logic [2:0]        cr_addr_i,
  input  logic [DATA_W-1:0] cr_wdata_i,
  output logic [DATA_W-1:0] cr_rdata_o,
  output logic              if_stall_o,
  output logic              id_stall_o,
  output logic              ex_stall_o,
  output logic              mem_stall_o,
  output logic              if_flush_o,
  output logic              id_flush_o,
  output logic              ex_flush_o,
  output logic              mem_flush_o,
  output logic [ADDR_W-1:0] new_pc_o,
  output logic              int_detect_o
);

  // state    | meaning
  // ST_RUN   | normal operation, interrupts may be detected
  // ST_DRAIN | redirect in flight, int_detect blacked out for DRAIN_N unstalled cycles
  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  localparam logic [EXP_W-1:0] EXP_NO_EXP = '0;
  localparam logic [1:0]       DRAIN_LD   = 2'(DRAIN_N - 1);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              ie_q, ie_d, pie_q, pie_d;
  logic [IRQ_W-1:0]  mask_q, mask_d;
  logic [EXP_W-1:0]  code_q, code_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [ADDR_W-1:0] vec_q, vec_d;
  logic              int_q, int_d;
  logic              g_stall, exc, eret;
  logic              unused_wdata;

  assign unused_wdata = ^cr_wdata_i[DATA_W-1:ADDR_W];
  assign int_detect_o = int_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      ie_q    <= 1'b0;
      pie_q   <= 1'b0;
      mask_q  <= '1;
      code_q  <= EXP_NO_EXP;
      epc_q   <= '0;
      vec_q   <= VEC_RST;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ie_q    <= ie_d;
      pie_q   <= pie_d;
      mask_q  <= mask_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      vec_q   <= vec_d;
      int_q   <= int_d;
    end
  end

  always_comb begin
    g_stall     = if_busy_i | mem_busy_i;
    exc         = mem_en_i & (mem_exp_code_i != EXP_NO_EXP);
    eret        = mem_en_i & mem_eret_i;
    if_stall_o  = 1'b0;
    id_stall_o  = 1'b0;
    ex_stall_o  = 1'b0;
    mem_stall_o = 1'b0;
    if_flush_o  = 1'b0;
    id_flush_o  = 1'b0;
    ex_flush_o  = 1'b0;
    mem_flush_o = 1'b0;
    new_pc_o    = '0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    ie_d        = ie_q;
    pie_d       = pie_q;
    mask_d      = mask_q;
    code_d      = code_q;
    epc_d       = epc_q;
    vec_d       = vec_q;
    int_d       = int_q;

    if (g_stall) begin
      // Bus wait freezes everything, including pending commits and int_detect.
      if_stall_o  = 1'b1;
      id_stall_o  = 1'b1;
      ex_stall_o  = 1'b1;
      mem_stall_o = 1'b1;
    end else begin
      int_d = (state_q == ST_RUN) & ie_q & (|(irq_i & ~mask_q)) & ~(exc | eret);
      if (exc) begin
        if_flush_o  = 1'b1;
        id_flush_o  = 1'b1;
        ex_flush_o  = 1'b1;
        mem_flush_o = 1'b1;
        new_pc_o    = vec_q;
        epc_d       = mem_br_flag_i ? (mem_pc_i - ADDR_W'(1)) : mem_pc_i;
        code_d      = mem_exp_code_i;
        pie_d       = ie_q;
        ie_d        = 1'b0;
        state_d     = ST_DRAIN;
        cnt_d       = DRAIN_LD;
      end else if (eret) begin
        if_flush_o  = 1'b1;
        id_flush_o  = 1'b1;
        ex_flush_o  = 1'b1;
        mem_flush_o = 1'b1;
        new_pc_o    = epc_q;
        ie_d        = pie_q;
        state_d     = ST_DRAIN;
        cnt_d       = DRAIN_LD;
      end else begin
        if (ld_hazard_i) begin
          if_stall_o = 1'b1;
          id_flush_o = 1'b1;
        end
        if (cr_we_i & mem_en_i) begin
          case (cr_addr_i)
            3'd0:    begin ie_d = cr_wdata_i[0]; pie_d = cr_wdata_i[1]; end
            3'd1:    mask_d = cr_wdata_i[IRQ_W-1:0];
            3'd2:    code_d = cr_wdata_i[EXP_W-1:0];
            3'd3:    epc_d  = cr_wdata_i[ADDR_W-1:0];
            3'd4:    vec_d  = cr_wdata_i[ADDR_W-1:0];
            default: ;
          endcase
        end
        if (state_q == ST_DRAIN) begin
          if (cnt_q == 2'd0) state_d = ST_RUN;
          else               cnt_d   = cnt_q - 2'd1;
        end
      end
    end
  end

  always_comb begin
    case (cr_addr_i)
      3'd0:    cr_rdata_o = DATA_W'({pie_q, ie_q});
      3'd1:    cr_rdata_o = DATA_W'(mask_q);
      3'd2:    cr_rdata_o = DATA_W'(code_q);
      3'd3:    cr_rdata_o = DATA_W'(epc_q);
      3'd4:    cr_rdata_o = DATA_W'(vec_q);
      default: cr_rdata_o = '0;
    endcase
  end

endmodule
